adder_measure_sequencer: RTL and testbench

Sequencer that drives the instrumented ring-oscillator adder through automated delay measurements. It sweeps over a programmable set of adder bit positions, configures the ring path for each, loads and runs the integration counter, captures the ring-cycle count, and hands each result out over a valid/ready port. It sits between the register/Wishbone front end and the adder instance, replacing direct pad control of the loop and counter pins.

---
 rtl/adder_seq_pkg.sv | 14 +
 rtl/adder_seq_settle_timer.sv | 20 ++
 rtl/adder_measure_sequencer.sv | 133 +++++++++++++
 tb/tb_adder_measure_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared state encoding, reference index and ring-select helper for the measurement sequencer
package adder_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, COUNT, CAPTURE, OUTPUT, NEXT} seq_state_t;
  localparam int unsigned SEL_MAX_W = 64;
  // The bypass reference result is tagged one past the highest real bit index.
  function automatic int unsigned ref_index(input int unsigned width);
    return width;
  endfunction
  // Active-low one-hot ring select; caller truncates to its WIDTH. An index at or
  // past WIDTH (the bypass reference) therefore yields all-ones after truncation.
  function automatic logic [SEL_MAX_W-1:0] sel_b(input int unsigned idx, input logic en);
    return en ? ~(SEL_MAX_W'(1) << idx) : '1;
  endfunction
endpackage

// File: rtl/adder_seq_settle_timer.sv
// adder_seq_settle_timer: loadable down-counter that flags when the ring settle time has elapsed
//   clk, reset_b : clock, async active-low reset
//   load         : reload with CYCLES-1 (asserted during the LOAD state)
//   expired      : counter at zero
module adder_seq_settle_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset_b,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) cnt <= '0;
    else if (load) cnt <= W'(CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: sweeps adder bit positions through ring-oscillator delay measurements
//   start/abort/bit_mask/integration_time : control from the register front end
//   stop_b, bypass_b, *_ring_bit_b        : ring path configuration (active-low)
//   counter_load/enable, integration_time_out, done, ring_osc_counter : integration counter
//   result_valid/ready/bit/count           : per-measurement result stream
//   busy, sweep_done                       : status
//   ADDER_SEQ_BYPASS_REF_EN : prepend a bypass reference measurement to every sweep
module adder_measure_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT_W = 32,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WIDTH-1:0]          bit_mask,
  input  logic [COUNT_W-1:0]        integration_time,
  output logic                      stop_b,
  output logic                      bypass_b,
  output logic [WIDTH-1:0]          a_input_ring_bit_b,
  output logic [WIDTH-1:0]          s_output_bit_b,
  output logic                      counter_load,
  output logic                      counter_enable,
  output logic [COUNT_W-1:0]        integration_time_out,
  input  logic                      done,
  input  logic [COUNT_W-1:0]        ring_osc_counter,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [$clog2(WIDTH):0]    result_bit,
  output logic [COUNT_W-1:0]        result_count,
  output logic                      busy,
  output logic                      sweep_done
);
  localparam int RB_W = $clog2(WIDTH) + 1;
  localparam logic [RB_W-1:0] REF_BIT = RB_W'(ref_index(WIDTH));
  seq_state_t state, state_d;
  logic [RB_W-1:0] idx, idx_d, nxt;
  logic [WIDTH-1:0] mask;
  logic found, sweep_d, expired, sel_on;
  // Lowest set bit above the current index; from IDLE (or after the reference) search the whole mask.
  always_comb begin
    found = 1'b0;
    nxt = '0;
    for (int j = WIDTH - 1; j >= 0; j--)
      if ((state == IDLE ? bit_mask[j] : mask[j]) && (state == IDLE || idx == REF_BIT || j > int'(idx))) begin
        found = 1'b1;
        nxt = RB_W'(j);
      end
  end
  always_comb begin
    state_d = state;
    idx_d = idx;
    sweep_d = 1'b0;
    case (state)
      IDLE: if (start) begin
`ifdef ADDER_SEQ_BYPASS_REF_EN
        state_d = LOAD;
        idx_d = REF_BIT;
`else
        state_d = found ? LOAD : IDLE;
        idx_d = nxt;
        sweep_d = !found;
`endif
      end
      LOAD: state_d = SETTLE;
      SETTLE: state_d = expired ? COUNT : SETTLE;
      COUNT: state_d = done ? CAPTURE : COUNT;
      CAPTURE: state_d = OUTPUT;
      OUTPUT: state_d = result_ready ? NEXT : OUTPUT;
      NEXT: begin
        state_d = found ? LOAD : IDLE;
        idx_d = nxt;
        sweep_d = !found;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      sweep_d = 1'b0;
    end
  end
  assign sel_on = state_d inside {LOAD, SETTLE, COUNT, CAPTURE};
  adder_seq_settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
    .clk(clk), .reset_b(reset_b), .load(state == LOAD), .expired(expired)
  );
  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      idx <= '0;
      mask <= '0;
      stop_b <= 1'b0;
      a_input_ring_bit_b <= '1;
      s_output_bit_b <= '1;
      counter_load <= 1'b0;
      counter_enable <= 1'b0;
      integration_time_out <= '0;
      result_valid <= 1'b0;
      result_bit <= '0;
      result_count <= '0;
      busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      if (state == IDLE && start && !abort) begin
        mask <= bit_mask;
        integration_time_out <= integration_time;
      end
      stop_b <= state_d inside {LOAD, SETTLE, COUNT};
      a_input_ring_bit_b <= WIDTH'(sel_b(32'(idx_d), sel_on));
      s_output_bit_b <= WIDTH'(sel_b(32'(idx_d), sel_on));
      counter_load <= state_d == LOAD;
      counter_enable <= state_d == COUNT;
      result_valid <= state_d == OUTPUT;
      busy <= state_d != IDLE;
      sweep_done <= sweep_d;
      if (state == CAPTURE && !abort) begin
        result_count <= ring_osc_counter;
        result_bit <= idx;
      end
    end
`ifdef ADDER_SEQ_BYPASS_REF_EN
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) bypass_b <= 1'b1;
    else bypass_b <= !(idx_d == REF_BIT && state_d inside {LOAD, SETTLE, COUNT, CAPTURE, OUTPUT});
`else
  assign bypass_b = 1'b1;
`endif
endmodule

// File: tb/tb_adder_measure_sequencer.sv
// tb_adder_measure_sequencer: directed checks of the measurement sequencer against hand-computed values
module tb_adder_measure_sequencer;
  logic clk = 1'b0;
  logic reset_b, start, abort, done, result_ready;
  logic [3:0] bit_mask, a_sel, s_sel;
  logic [31:0] integration_time, itime_out, ring, result_count;
  logic stop_b, bypass_b, counter_load, counter_enable, result_valid, busy, sweep_done;
  logic [2:0] result_bit;
  int n_chk = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;
  adder_measure_sequencer dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .bit_mask(bit_mask),
    .integration_time(integration_time), .stop_b(stop_b), .bypass_b(bypass_b),
    .a_input_ring_bit_b(a_sel), .s_output_bit_b(s_sel), .counter_load(counter_load),
    .counter_enable(counter_enable), .integration_time_out(itime_out), .done(done),
    .ring_osc_counter(ring), .result_valid(result_valid), .result_ready(result_ready),
    .result_bit(result_bit), .result_count(result_count), .busy(busy), .sweep_done(sweep_done)
  );
  // Integration counter model: reloads on counter_load, reports done 20 enabled cycles later.
  always @(posedge clk)
    if (counter_load) cyc <= 0;
    else if (counter_enable) cyc <= cyc + 1;
  assign done = cyc >= 20;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_stop"}, 64'(stop_b), 64'h0);
    check({tag, "_bypass"}, 64'(bypass_b), 64'h1);
    check({tag, "_asel"}, 64'(a_sel), 64'hF);
    check({tag, "_ssel"}, 64'(s_sel), 64'hF);
    check({tag, "_load"}, 64'(counter_load), 64'h0);
    check({tag, "_en"}, 64'(counter_enable), 64'h0);
    check({tag, "_itime"}, 64'(itime_out), 64'h0);
    check({tag, "_valid"}, 64'(result_valid), 64'h0);
    check({tag, "_rbit"}, 64'(result_bit), 64'h0);
    check({tag, "_rcount"}, 64'(result_count), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_sdone"}, 64'(sweep_done), 64'h0);
  endtask
  task automatic wait_valid(input string tag);
    for (int k = 0; k < 300 && !result_valid; k++) tick();
    check({tag, "_valid"}, 64'(result_valid), 64'h1);
  endtask
  task automatic go(input logic [3:0] m, input logic [31:0] it);
    bit_mask = m;
    integration_time = it;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    logic seen;
    reset_b = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b1;
    bit_mask = '0; integration_time = '0; ring = 32'h1234;
    #1 reset_b = 1'b0;
    #1 check_idle("rst");
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    tick();
`ifdef ADDER_SEQ_BYPASS_REF_EN
    go(4'b1000, 32'd100);
    check("ref_load", 64'(counter_load), 64'h1);
    check("ref_bypass", 64'(bypass_b), 64'h0);
    check("ref_asel", 64'(a_sel), 64'hF);
    wait_valid("ref");
    check("ref_bit", 64'(result_bit), 64'h4);
    check("ref_count", 64'(result_count), 64'h1234);
    check("ref_bypass_out", 64'(bypass_b), 64'h0);
    tick(); tick();
    check("b3_load", 64'(counter_load), 64'h1);
    check("b3_bypass", 64'(bypass_b), 64'h1);
    check("b3_asel", 64'(a_sel), 64'h7);
    wait_valid("b3");
    check("b3_bit", 64'(result_bit), 64'h3);
    check("b3_count", 64'(result_count), 64'h1234);
    tick(); tick();
    check("ref_sdone", 64'(sweep_done), 64'h1);
    check("ref_busy", 64'(busy), 64'h0);
`else
    go(4'b0000, 32'd7);
    check("empty_sdone", 64'(sweep_done), 64'h1);
    check("empty_busy", 64'(busy), 64'h0);
    check("empty_load", 64'(counter_load), 64'h0);
    check("empty_valid", 64'(result_valid), 64'h0);
    check("empty_itime", 64'(itime_out), 64'd7);
    tick();
    check("empty_sdone_low", 64'(sweep_done), 64'h0);
    go(4'b0101, 32'd100);
    check("b0_load", 64'(counter_load), 64'h1);
    check("b0_busy", 64'(busy), 64'h1);
    check("b0_stop", 64'(stop_b), 64'h1);
    check("b0_asel", 64'(a_sel), 64'hE);
    check("b0_ssel", 64'(s_sel), 64'hE);
    check("b0_itime", 64'(itime_out), 64'd100);
    repeat (16) tick();
    check("b0_settle_end", 64'(counter_enable), 64'h0);
    tick();
    check("b0_count_en", 64'(counter_enable), 64'h1);
    check("b0_count_asel", 64'(a_sel), 64'hE);
    wait_valid("b0");
    check("b0_bit", 64'(result_bit), 64'h0);
    check("b0_count", 64'(result_count), 64'h1234);
    check("b0_out_stop", 64'(stop_b), 64'h0);
    tick();
    check("b0_next_valid", 64'(result_valid), 64'h0);
    tick();
    check("b2_load", 64'(counter_load), 64'h1);
    check("b2_asel", 64'(a_sel), 64'hB);
    check("b2_ssel", 64'(s_sel), 64'hB);
    wait_valid("b2");
    check("b2_bit", 64'(result_bit), 64'h2);
    check("b2_count", 64'(result_count), 64'h1234);
    tick(); tick();
    check("sw_sdone", 64'(sweep_done), 64'h1);
    check("sw_busy", 64'(busy), 64'h0);
    tick();
    check("sw_sdone_low", 64'(sweep_done), 64'h0);
    result_ready = 1'b0;
    ring = 32'h00ABCDEF;
    go(4'b0110, 32'd100);
    wait_valid("stall");
    ring = 32'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_valid", 64'(result_valid), 64'h1);
      check("stall_bit", 64'(result_bit), 64'h1);
      check("stall_count", 64'(result_count), 64'hABCDEF);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("stall_next_valid", 64'(result_valid), 64'h0);
    tick();
    check("stall_load", 64'(counter_load), 64'h1);
    check("stall_asel", 64'(a_sel), 64'hB);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_load_busy", 64'(busy), 64'h0);
    check("ab_load_stop", 64'(stop_b), 64'h0);
    ring = 32'h1234;
    result_ready = 1'b1;
    go(4'b0010, 32'd100);
    for (int k = 0; k < 100 && !counter_enable; k++) tick();
    check("ab_reach_count", 64'(counter_enable), 64'h1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 64'(busy), 64'h0);
    check("ab_stop", 64'(stop_b), 64'h0);
    check("ab_en", 64'(counter_enable), 64'h0);
    check("ab_valid", 64'(result_valid), 64'h0);
    check("ab_asel", 64'(a_sel), 64'hF);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (result_valid || sweep_done || busy) seen = 1'b1;
    end
    check("ab_quiet", 64'(seen), 64'h0);
    abort = 1'b1;
    go(4'b0001, 32'd55);
    abort = 1'b0;
    check("sa_busy", 64'(busy), 64'h0);
    check("sa_load", 64'(counter_load), 64'h0);
    check("sa_itime", 64'(itime_out), 64'd100);
    tick();
    check("sa_busy2", 64'(busy), 64'h0);
`endif
    go(4'b0001, 32'd100);
    check("mr_load", 64'(counter_load), 64'h1);
    repeat (3) tick();
    check("mr_busy", 64'(busy), 64'h1);
    #2 reset_b = 1'b0;
    #1 check_idle("midrst");
    @(posedge clk);
    #1 reset_b = 1'b1;
    tick();
    go(4'b1000, 32'd100);
`ifdef ADDER_SEQ_BYPASS_REF_EN
    wait_valid("pr_ref");
    check("pr_ref_bit", 64'(result_bit), 64'h4);
    tick(); tick();
`endif
    check("pr_load", 64'(counter_load), 64'h1);
    check("pr_asel", 64'(a_sel), 64'h7);
    wait_valid("pr");
    check("pr_bit", 64'(result_bit), 64'h3);
    check("pr_count", 64'(result_count), 64'h1234);
    tick(); tick();
    check("pr_sdone", 64'(sweep_done), 64'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
